design_1_led_gpio: RTL and testbench
====================================

Name: design_1_led_gpio

Overview:
- AXI4-Lite slave GPIO block driving the 8 Nexys Video user LEDs (LD[7:0]).
- A bus master, the AXI VIP in simulation or a CPU in hardware, writes a data register, and that value appears on LD.
- Sits at the top of the board design, between the system AXI interconnect and the LED pins.
- Base offset 0x0; register space decoded on addr[3:2].

Parameters:
- C_ADDR_WIDTH, 9: AXI-Lite address width.
- C_DATA_WIDTH, 32: AXI-Lite data width; only 32 is supported.
- C_GPIO_WIDTH, 8: number of LED outputs; range 1..32.
- C_DOUT_DEFAULT, 0: reset value of the GPIO_DATA register and LD.

Ports:
- aclk  in  1  system clock.
- aresetn  in  1  asynchronous active-low reset.
- s_axi_awaddr  in  C_ADDR_WIDTH  write address.
- s_axi_awprot  in  3  ignored.
- s_axi_awvalid / s_axi_awready  in/out  1  write-address handshake.
- s_axi_wdata  in  32  write data.
- s_axi_wstrb  in  4  byte strobes.
- s_axi_wvalid / s_axi_wready  in/out  1  write-data handshake.
- s_axi_bresp  out  2  write response.
- s_axi_bvalid / s_axi_bready  out/in  1  write-response handshake.
- s_axi_araddr  in  C_ADDR_WIDTH  read address.
- s_axi_arprot  in  3  ignored.
- s_axi_arvalid / s_axi_arready  in/out  1  read-address handshake.
- s_axi_rdata  out  32  read data.
- s_axi_rresp  out  2  read response.
- s_axi_rvalid / s_axi_rready  out/in  1  read-data handshake.
- LD  out  C_GPIO_WIDTH  LED outputs, driven from a register.

Behaviour:
- Reset (aresetn low, asynchronous):
  - GPIO_DATA = C_DOUT_DEFAULT, so LD = 0x00.
  - All ready and valid outputs are 0; bresp/rresp = 0; rdata = 0.
  - Reset asserted mid-transaction abandons the transaction; there is no response afterwards.
- Register map:
  - 0x0 GPIO_DATA: RW, bits [C_GPIO_WIDTH-1:0]; upper bits read 0.
  - 0x4 GPIO_TRI: reserved; reads 0, writes ignored, response OKAY.
  - Any other offset: reads 0, writes ignored, response SLVERR (2'b10).
- Write channel:
  - awready and wready assert independently, each when its address/data is not yet latched and bvalid = 0.
  - AW and W may arrive in either order or in the same cycle.
  - Once both are latched, the register is updated on the next clock edge and bvalid asserts on that same edge.
  - bvalid holds until bready; no new AW/W is accepted until the B handshake completes (one outstanding write).
  - Write updates LD on the clock edge after the second of AW/W is captured.
  - wstrb[n] gates byte n; bits beyond C_GPIO_WIDTH are dropped.
- Read channel:
  - arready = 1 when rvalid = 0.
  - On an AR handshake, rvalid asserts the next cycle with rdata and rresp.
  - rdata/rresp hold stable until rready.
  - A read of 0x0 returns the current GPIO_DATA.
  - Reads and writes are independent; a read in the same cycle as a GPIO_DATA update returns the pre-update value.
- Address decode ignores addr[1:0] and bits above addr[3:2] within the 0x0-0xF window; addresses >= 0x10 are out of range.

Optional Feature:
- Macro: DESIGN_1_LED_TOGGLE_EN.
- Defined: offset 0x8 GPIO_TOGGLE is a write-only register; writing it XORs the strobed data bits into GPIO_DATA; reads of it return 0; response OKAY.
- Undefined: 0x8 behaves as an unmapped offset (SLVERR, no effect).

Decomposition:
- Package design_1_led_gpio_pkg holds:
  - register offset constants (GPIO_DATA_OFS, GPIO_TRI_OFS, GPIO_TOGGLE_OFS);
  - RESP_OKAY / RESP_SLVERR constants;
  - an axi_resp_t typedef.
- One sub-module is natural: axil_slave_if, containing the AXI-Lite handshake logic and exposing a simple reg write/read strobe interface.
- GPIO register logic stays in the top module.

Test Plan:
- Reset: hold aresetn low 100 ns -> LD = 0x00, all valid outputs 0; release -> idle.
- Write 0xAA to 0x0 with wstrb=0xF, AW and W in the same cycle -> bresp OKAY; LD = 0xAA one cycle after capture; read 0x0 returns 0x000000AA.
- Write with W before AW, then AW before W, with bready held low 3 cycles -> LD updates once per write; bvalid stays high until bready; no second write accepted meanwhile.
- Write 0x55 to 0x0 with wstrb=0x0 -> LD unchanged, OKAY.
- Write to 0x4 and 0x10 -> LD unchanged; 0x4 OKAY, 0x10 SLVERR; reads return 0 with matching resp.
- With DESIGN_1_LED_TOGGLE_EN, GPIO_DATA=0xAA, write 0x0F to 0x8 -> LD = 0xA5; without the macro -> SLVERR and LD = 0xAA.

Source files
------------

// File: rtl/design_1_led_gpio_pkg.sv
// Shared constants, response type and register-select decode for the LED GPIO block.
// DESIGN_1_LED_TOGGLE_EN adds the write-only GPIO_TOGGLE register at offset 0x8.
package design_1_led_gpio_pkg;

  localparam logic [3:0] GPIO_DATA_OFS   = 4'h0;
  localparam logic [3:0] GPIO_TRI_OFS    = 4'h4;
  localparam logic [3:0] GPIO_TOGGLE_OFS = 4'h8;

  typedef logic [1:0] axi_resp_t;

  localparam axi_resp_t RESP_OKAY   = 2'b00;
  localparam axi_resp_t RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    SEL_DATA,
    SEL_TRI,
    SEL_TOGGLE,
    SEL_NONE
  } reg_sel_t;

  // Only addr[3:2] selects a register inside the 16-byte window.
  function automatic reg_sel_t decode_sel(input logic in_range, input logic [1:0] word);
    logic [3:0] ofs;
    ofs = {word, 2'b00};
    if (!in_range) return SEL_NONE;
    case (ofs)
      GPIO_DATA_OFS:   return SEL_DATA;
      GPIO_TRI_OFS:    return SEL_TRI;
`ifdef DESIGN_1_LED_TOGGLE_EN
      GPIO_TOGGLE_OFS: return SEL_TOGGLE;
`endif
      default:         return SEL_NONE;
    endcase
  endfunction

  function automatic axi_resp_t sel_resp(input reg_sel_t sel);
    return (sel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/design_1_led_gpio_axil_slave_if.sv
// AXI4-Lite slave handshake engine: one outstanding write and one outstanding read,
// presented to the register logic as single-cycle write/read strobes.
module design_1_led_gpio_axil_slave_if
  import design_1_led_gpio_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready,

  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [DATA_W-1:0]   wr_data,
  output logic [DATA_W/8-1:0] wr_strb,
  input  axi_resp_t           wr_resp,
  output logic                rd_en,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic [DATA_W-1:0]   rd_data,
  input  axi_resp_t           rd_resp
);

  logic ready_en;
  logic aw_full;
  logic w_full;

  // Keeps every ready low while reset is asserted and for the first cycle after it.
  // NOTE: state uses non-blocking assignments with async reset so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  assign s_axi_awready = ready_en && !aw_full && !s_axi_bvalid;
  assign s_axi_wready  = ready_en && !w_full  && !s_axi_bvalid;
  assign s_axi_arready = ready_en && !s_axi_rvalid;

  assign wr_en = aw_full && w_full && !s_axi_bvalid;
  assign rd_en = s_axi_arvalid && s_axi_arready;
  assign rd_addr = s_axi_araddr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_full      <= 1'b0;
      w_full       <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      wr_strb      <= '0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= RESP_OKAY;
    end else begin
      if (s_axi_awvalid && s_axi_awready) begin
        aw_full <= 1'b1;
        wr_addr <= s_axi_awaddr;
      end
      if (s_axi_wvalid && s_axi_wready) begin
        w_full  <= 1'b1;
        wr_data <= s_axi_wdata;
        wr_strb <= s_axi_wstrb;
      end
      if (wr_en) begin
        aw_full      <= 1'b0;
        w_full       <= 1'b0;
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= wr_resp;
      end else if (s_axi_bvalid && s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= RESP_OKAY;
    end else if (rd_en) begin
      s_axi_rvalid <= 1'b1;
      s_axi_rdata  <= rd_data;
      s_axi_rresp  <= rd_resp;
    end else if (s_axi_rvalid && s_axi_rready) begin
      s_axi_rvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/design_1_led_gpio.sv
// AXI4-Lite GPIO driving the board LEDs from the GPIO_DATA register.
// Define DESIGN_1_LED_TOGGLE_EN to enable the GPIO_TOGGLE register at offset 0x8.
module design_1_led_gpio
  import design_1_led_gpio_pkg::*;
#(
  parameter int          C_ADDR_WIDTH   = 9,
  parameter int          C_DATA_WIDTH   = 32,
  parameter int          C_GPIO_WIDTH   = 8,
  parameter logic [31:0] C_DOUT_DEFAULT = 32'h0
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [C_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]                s_axi_awprot,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [C_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [C_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [C_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]                s_axi_arprot,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [C_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic [C_GPIO_WIDTH-1:0]   LD
);

  logic                      wr_en;
  logic [C_ADDR_WIDTH-1:0]   wr_addr;
  logic [C_DATA_WIDTH-1:0]   wr_data;
  logic [C_DATA_WIDTH/8-1:0] wr_strb;
  axi_resp_t                 wr_resp;
  logic                      rd_en;
  logic [C_ADDR_WIDTH-1:0]   rd_addr;
  logic [C_DATA_WIDTH-1:0]   rd_data;
  axi_resp_t                 rd_resp;

  reg_sel_t                  wr_sel;
  reg_sel_t                  rd_sel;
  logic [C_GPIO_WIDTH-1:0]   gpio_q;
  logic [C_GPIO_WIDTH-1:0]   gpio_next;

  design_1_led_gpio_axil_slave_if #(
    .ADDR_W (C_ADDR_WIDTH),
    .DATA_W (C_DATA_WIDTH)
  ) u_axil (
    .clk           (aclk),
    .rst_n         (aresetn),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_strb       (wr_strb),
    .wr_resp       (wr_resp),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .rd_resp       (rd_resp)
  );

  // Anything at or above 0x10 falls outside the register window.
  assign wr_sel  = decode_sel(wr_addr[C_ADDR_WIDTH-1:4] == '0, wr_addr[3:2]);
  assign rd_sel  = decode_sel(rd_addr[C_ADDR_WIDTH-1:4] == '0, rd_addr[3:2]);
  assign wr_resp = sel_resp(wr_sel);
  assign rd_resp = sel_resp(rd_sel);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    gpio_next = gpio_q;
    if (wr_en) begin
      case (wr_sel)
        SEL_DATA: begin
          for (int i = 0; i < C_GPIO_WIDTH; i++)
            if (wr_strb[i/8]) gpio_next[i] = wr_data[i];
        end
        SEL_TOGGLE: begin
          for (int i = 0; i < C_GPIO_WIDTH; i++)
            if (wr_strb[i/8]) gpio_next[i] = gpio_q[i] ^ wr_data[i];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) gpio_q <= C_DOUT_DEFAULT[C_GPIO_WIDTH-1:0];
    else          gpio_q <= gpio_next;
  end

  always_comb begin
    rd_data = '0;
    if (rd_sel == SEL_DATA) rd_data = C_DATA_WIDTH'(gpio_q);
  end

  assign LD = gpio_q;

  // Protection bits and the byte-lane bits of the address carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{s_axi_awprot, s_axi_arprot, wr_addr[1:0], rd_addr[1:0],
                       wr_data, wr_strb, rd_en};

endmodule

// File: tb/tb_design_1_led_gpio.sv
// Self-checking bench for design_1_led_gpio: B and R responses go through scoreboard queues,
// LD is checked against a small register model.
module tb_design_1_led_gpio;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [8:0]  s_axi_awaddr = '0;
  logic [2:0]  s_axi_awprot = '0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b0;
  logic [8:0]  s_axi_araddr = '0;
  logic [2:0]  s_axi_arprot = '0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b0;
  logic [7:0]  LD;

  int tests_run = 0;
  int tests_failed = 0;

  logic [1:0]  b_q[$];
  logic [33:0] r_q[$];
  logic [7:0]  ld_model = 8'h00;

  always #5 aclk = ~aclk;

  design_1_led_gpio dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awprot  (s_axi_awprot),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arprot  (s_axi_arprot),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .LD            (LD)
  );

  task automatic check(input string tag, input logic [33:0] got, input logic [33:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference register map: expected response for an offset and the effect of a write.
  function automatic logic [1:0] exp_resp(input logic [8:0] addr);
    if (addr >= 9'h10) return 2'b10;
    case (addr[3:2])
      2'd0, 2'd1: return 2'b00;
`ifdef DESIGN_1_LED_TOGGLE_EN
      2'd2:       return 2'b00;
`endif
      default:    return 2'b10;
    endcase
  endfunction

  function automatic logic [7:0] exp_ld(input logic [8:0] addr, input logic [31:0] data,
                                        input logic [3:0] strb, input logic [7:0] cur);
    if (addr >= 9'h10 || !strb[0]) return cur;
    if (addr[3:2] == 2'd0) return data[7:0];
`ifdef DESIGN_1_LED_TOGGLE_EN
    if (addr[3:2] == 2'd2) return cur ^ data[7:0];
`endif
    return cur;
  endfunction

  // mode 0: AW and W together, 1: W before AW, 2: AW before W. Called and returns on a negedge.
  task automatic axi_write(input logic [8:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int mode, input int bhold);
    logic [7:0] old_ld;
    logic aw_left, w_left, aw_hs, w_hs;
    logic [1:0] r;
    old_ld   = ld_model;
    ld_model = exp_ld(addr, data, strb, ld_model);
    b_q.push_back(exp_resp(addr));
    s_axi_awaddr = addr;
    s_axi_wdata  = data;
    s_axi_wstrb  = strb;
    aw_left = 1'b1;
    w_left  = 1'b1;
    s_axi_awvalid = (mode != 1);
    s_axi_wvalid  = (mode != 2);
    for (int c = 0; c < 40 && (aw_left || w_left); c++) begin
      aw_hs = s_axi_awvalid && s_axi_awready;
      w_hs  = s_axi_wvalid && s_axi_wready;
      @(negedge aclk);
      if (aw_hs) begin s_axi_awvalid = 1'b0; aw_left = 1'b0; end
      if (w_hs)  begin s_axi_wvalid  = 1'b0; w_left  = 1'b0; end
      if (mode == 1 && !w_left && aw_left) s_axi_awvalid = 1'b1;
      if (mode == 2 && !aw_left && w_left) s_axi_wvalid  = 1'b1;
    end
    if (aw_left || w_left) check("wr_addr_data_timeout", 0, 1);
    check("ld_before_update", LD, old_ld);
    @(negedge aclk);
    check("bvalid_asserted", s_axi_bvalid, 1);
    check("ld_after_update", LD, ld_model);
    for (int c = 0; c < bhold; c++) begin
      check("bvalid_held", s_axi_bvalid, 1);
      check("awready_blocked", s_axi_awready, 0);
      check("wready_blocked", s_axi_wready, 0);
      check("ld_stable_in_b", LD, ld_model);
      @(negedge aclk);
    end
    s_axi_bready = 1'b1;
    if (s_axi_bvalid && b_q.size() > 0) begin
      r = b_q.pop_front();
      check("bresp", s_axi_bresp, r);
    end else begin
      check("bvalid_lost", s_axi_bvalid, 1);
    end
    @(negedge aclk);
    s_axi_bready = 1'b0;
    check("bvalid_cleared", s_axi_bvalid, 0);
  endtask

  task automatic axi_read(input logic [8:0] addr);
    logic [33:0] e;
    logic done;
    e = {exp_resp(addr), 32'h0};
    if (addr < 9'h10 && addr[3:2] == 2'd0) e[31:0] = {24'h0, ld_model};
    r_q.push_back(e);
    s_axi_araddr  = addr;
    s_axi_arvalid = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      done = s_axi_arready;
      @(negedge aclk);
    end
    s_axi_arvalid = 1'b0;
    if (!done) check("ar_timeout", 0, 1);
    check("rvalid_asserted", s_axi_rvalid, 1);
    @(negedge aclk);
    check("rvalid_held", s_axi_rvalid, 1);
    s_axi_rready = 1'b1;
    if (s_axi_rvalid && r_q.size() > 0) begin
      e = r_q.pop_front();
      check("rdata_rresp", {s_axi_rresp, s_axi_rdata}, e);
    end
    @(negedge aclk);
    s_axi_rready = 1'b0;
    check("rvalid_cleared", s_axi_rvalid, 0);
  endtask

  initial begin
    #95;
    check("rst_ld", LD, 8'h00);
    check("rst_bvalid", s_axi_bvalid, 0);
    check("rst_rvalid", s_axi_rvalid, 0);
    check("rst_awready", s_axi_awready, 0);
    check("rst_wready", s_axi_wready, 0);
    check("rst_arready", s_axi_arready, 0);
    check("rst_rdata", s_axi_rdata, 0);
    check("rst_resps", {s_axi_bresp, s_axi_rresp}, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    @(negedge aclk);
    check("idle_ready", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);
    check("idle_ld", LD, 8'h00);

    axi_write(9'h000, 32'h0000_00AA, 4'hF, 0, 0);
    axi_read(9'h000);
    axi_write(9'h000, 32'h0000_003C, 4'hF, 1, 3);
    axi_write(9'h000, 32'h0000_00C3, 4'hF, 2, 3);
    axi_read(9'h001);
    axi_write(9'h000, 32'h0000_0055, 4'h0, 0, 0);
    axi_write(9'h000, 32'hFFFF_FF12, 4'h1, 2, 1);
    axi_write(9'h000, 32'h1234_56FF, 4'hE, 1, 0);
    axi_read(9'h000);
    axi_write(9'h004, 32'h0000_00FF, 4'hF, 0, 0);
    axi_write(9'h010, 32'h0000_00FF, 4'hF, 0, 2);
    axi_read(9'h004);
    axi_read(9'h010);
    axi_read(9'h00C);
    axi_write(9'h000, 32'h0000_00AA, 4'hF, 0, 0);
    axi_write(9'h008, 32'h0000_000F, 4'hF, 0, 0);
    check("toggle_ld", LD, ld_model);
    axi_read(9'h008);
    axi_read(9'h000);
    check("scoreboard_empty", b_q.size() + r_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
